// File: rtl/io_stub_pkg.sv
// Shared types and encodings for the I/O stub register bank and its write log.
package io_stub_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] port;
    logic [15:0] value;
  } log_entry_t;

  localparam logic LANE_LO  = 1'b0;
  localparam logic LANE_HI  = 1'b1;
  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;
  localparam logic BUS_WR   = 1'b0;
  localparam logic BUS_RD   = 1'b1;

  // Byte writes always source wr_data[7:0]; the lane only picks the destination.
  function automatic logic [15:0] merge_write(input logic [15:0] cur,
                                              input logic [15:0] wd,
                                              input logic        bm,
                                              input logic        hi);
    if (bm == ACC_WORD) return wd;
    if (hi == LANE_HI) return {wd[7:0], cur[7:0]};
    return {cur[15:8], wd[7:0]};
  endfunction

endpackage

// File: rtl/io_log_fifo.sv
// Synchronous FIFO for committed-write records; drops pushes when full and
// remembers that it did so in a sticky overflow flag.
module io_log_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           ovf_q;
  logic           pop_ok, push_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push_i && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/io_stub_bank.sv
// Window of NREGS 16-bit I/O registers with byte lanes, programmable wait
// states on a ready handshake, and a log of every committed write.
//
// state   | meaning
// IDLE    | no access in progress; a window hit starts one
// WAITING | counting down wait states, cnt_q holds cycles still to go
// DONE    | ready high for one cycle; writes commit on the edge leaving it
module io_stub_bank
  import io_stub_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h00b0,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned WAIT      = 0,
  parameter int unsigned LOG_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [19:0]                addr,
  input  logic [15:0]                wr_data,
  input  logic                       we,
  input  logic                       m_io,
  input  logic                       byte_m,
  output logic [15:0]                rd_data,
  output logic                       ready,
  output logic                       log_valid,
  output logic [31:0]                log_data,
  input  logic                       log_pop,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic                       log_ovf
);

  localparam int          IDXW    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [16:0] WIN_END = 17'(BASE) + 17'(2 * NREGS);
  localparam logic [3:0]  WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] regs_q [NREGS];

  logic [15:0]     port, offset, cur_val, reg_d;
  logic [IDXW-1:0] idx;
  logic            hit, hi, commit, log_empty;
  log_entry_t      push_entry, head_entry;
  logic            unused_bits, unused_log_full;

  assign port    = addr[15:0];
  assign hit     = m_io && ({1'b0, port} >= {1'b0, BASE}) && ({1'b0, port} < WIN_END);
  assign offset  = port - BASE;
  assign idx     = offset[IDXW:1];
  assign hi      = port[0];
  assign cur_val = regs_q[idx];
  assign reg_d   = merge_write(cur_val, wr_data, byte_m, hi);
  assign commit  = (state_q == DONE) && hit && (we == BUS_WR);

  assign unused_bits = ^{addr[19:16], offset[15:IDXW+1], offset[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (WAIT == 0) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= WAIT_LD;
              state_q <= WAITING;
            end
          end
        end
        WAITING: begin
          if (!hit)               state_q <= IDLE;
          else if (cnt_q == 4'd0) state_q <= DONE;
          else                    cnt_q   <= cnt_q - 4'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (commit) regs_q[idx] <= reg_d;
    end
  end

  assign ready = (state_q == DONE) || !hit;

  always_comb begin
    rd_data = '0;
    if ((state_q == DONE) && hit && (we == BUS_RD)) begin
      if (byte_m == ACC_WORD)  rd_data = cur_val;
      else if (hi == LANE_HI)  rd_data = {8'h00, cur_val[15:8]};
      else                     rd_data = {8'h00, cur_val[7:0]};
    end
  end

  assign push_entry.port  = port;
  assign push_entry.value = reg_d;

  io_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .T     (log_entry_t)
  ) u_log (
    .clk         (clk),
    .rst         (rst),
    .push_i      (commit),
    .push_data_i (push_entry),
    .pop_i       (log_pop),
    .head_o      (head_entry),
    .full_o      (unused_log_full),
    .empty_o     (log_empty),
    .count_o     (log_count),
    .ovf_o       (log_ovf)
  );

  assign log_valid = !log_empty;
  assign log_data  = head_entry;

endmodule

// File: tb/tb_io_stub_bank.sv
// Bench for io_stub_bank: a zero-wait instance with a 4-deep log and a
// three-wait instance with a 16-deep log, checked against a register model.
module tb_io_stub_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic        we = 1'b1, m_io = 1'b0, byte_m = 1'b0, log_pop = 1'b0;
  int          sel = 0;

  logic        m_io0, m_io3, pop0, pop3;
  logic [15:0] rd0, rd3;
  logic        rdy0, rdy3, lv0, lv3, ovf0, ovf3;
  logic [31:0] ld0, ld3;
  logic [2:0]  lc0;
  logic [4:0]  lc3;

  logic [15:0] rd_s;
  logic        rdy_s, lv_s, ovf_s;
  logic [31:0] ld_s;
  int          cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mreg0 [8];
  logic [15:0] mreg3 [8];
  logic [31:0] exp0 [$];
  logic [31:0] exp3 [$];
  bit          eovf0, eovf3;

  assign m_io0 = m_io && (sel == 0);
  assign m_io3 = m_io && (sel != 0);
  assign pop0  = log_pop && (sel == 0);
  assign pop3  = log_pop && (sel != 0);

  always #5 clk = ~clk;

  io_stub_bank #(.BASE(16'h00b0), .NREGS(8), .WAIT(0), .LOG_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .we(we), .m_io(m_io0),
    .byte_m(byte_m), .rd_data(rd0), .ready(rdy0), .log_valid(lv0), .log_data(ld0),
    .log_pop(pop0), .log_count(lc0), .log_ovf(ovf0));

  io_stub_bank #(.BASE(16'h00b0), .NREGS(8), .WAIT(3), .LOG_DEPTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .we(we), .m_io(m_io3),
    .byte_m(byte_m), .rd_data(rd3), .ready(rdy3), .log_valid(lv3), .log_data(ld3),
    .log_pop(pop3), .log_count(lc3), .log_ovf(ovf3));

  always_comb begin
    rd_s  = (sel == 0) ? rd0 : rd3;
    rdy_s = (sel == 0) ? rdy0 : rdy3;
    lv_s  = (sel == 0) ? lv0 : lv3;
    ld_s  = (sel == 0) ? ld0 : ld3;
    ovf_s = (sel == 0) ? ovf0 : ovf3;
    cnt_s = (sel == 0) ? int'(lc0) : int'(lc3);
  end

  function automatic int qsize(input int s);
    return (s == 0) ? exp0.size() : exp3.size();
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mreg0[i] = '0;
      mreg3[i] = '0;
    end
    exp0.delete();
    exp3.delete();
    eovf0 = 1'b0;
    eovf3 = 1'b0;
  endfunction

  // Register update as seen from the bus: byte data always comes from bits 7:0.
  function automatic void model_write(input int s, input logic [15:0] port,
                                      input logic bm, input logic [15:0] data);
    int          i;
    logic [15:0] cur, nv;
    i   = int'((port - 16'h00b0) >> 1);
    cur = (s == 0) ? mreg0[i] : mreg3[i];
    if (!bm)          nv = data;
    else if (port[0]) nv = {data[7:0], cur[7:0]};
    else              nv = {cur[15:8], data[7:0]};
    if (s == 0) begin
      mreg0[i] = nv;
      if (exp0.size() < 4) exp0.push_back({port, nv});
      else eovf0 = 1'b1;
    end else begin
      mreg3[i] = nv;
      if (exp3.size() < 16) exp3.push_back({port, nv});
      else eovf3 = 1'b1;
    end
  endfunction

  function automatic logic [15:0] model_read(input int s, input logic [15:0] port,
                                             input logic bm);
    logic [15:0] cur;
    cur = (s == 0) ? mreg0[int'((port - 16'h00b0) >> 1)] : mreg3[int'((port - 16'h00b0) >> 1)];
    if (!bm) return cur;
    return port[0] ? {8'h00, cur[15:8]} : {8'h00, cur[7:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after ready.
  task automatic do_access(input int s, input logic [15:0] port, input logic wr,
                           input logic bm, input logic [15:0] data,
                           output logic [15:0] rdv, output logic [15:0] early,
                           output int lows);
    lows    = 0;
    sel     = s;
    addr    = {4'h0, port};
    we      = ~wr;
    byte_m  = bm;
    wr_data = data;
    m_io    = 1'b1;
    #1;
    early = rd_s;
    while (!rdy_s && lows < 50) begin
      lows++;
      @(posedge clk); #2;
    end
    if (lows >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout: port %h never got ready", port);
    end
    rdv = rd_s;
    @(posedge clk); #1;
    m_io = 1'b0;
    we   = 1'b1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    m_io = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain_log(input int s, input string tag);
    int guard;
    guard = 0;
    sel   = s;
    #1;
    while (qsize(s) > 0 && guard < 40) begin
      logic [31:0] e;
      if (s == 0) e = exp0.pop_front();
      else        e = exp3.pop_front();
      n_checks++;
      if (lv_s !== 1'b1 || ld_s !== e) begin
        n_fail++;
        $display("FAIL %s_log_entry: got valid %b data %h want valid 1 data %h", tag, lv_s, ld_s, e);
      end
      log_pop = 1'b1;
      @(posedge clk); #1;
      log_pop = 1'b0;
      #1;
      guard++;
    end
    n_checks++;
    if (lv_s !== 1'b0 || cnt_s !== 0) begin
      n_fail++;
      $display("FAIL %s_log_empty: got valid %b count %0d want valid 0 count 0", tag, lv_s, cnt_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    sel = 0;
    #1;
    n_checks++;
    if ({rdy0, rd0, lv0, lc0, ovf0} !== {1'b1, 16'h0000, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut0: got rdy %b rd %h lv %b cnt %0d ovf %b want 1 0000 0 0 0", rdy0, rd0, lv0, lc0, ovf0);
    end
    n_checks++;
    if ({rdy3, rd3, lv3, lc3, ovf3} !== {1'b1, 16'h0000, 1'b0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut3: got rdy %b rd %h lv %b cnt %0d ovf %b want 1 0000 0 0 0", rdy3, rd3, lv3, lc3, ovf3);
    end
    @(posedge clk); #1;
    // A hit held through reset must see IDLE: ready follows ~hit and stays low.
    rst  = 1'b1;
    addr = 20'h000b0;
    we   = 1'b1;
    m_io = 1'b1;
    #1;
    n_checks++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hit_ready: got %b want 0", rdy0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_ready: got %b want 0", rdy0);
    end
    m_io = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_write();
    logic [15:0] rdv, early;
    int lows;
    sel = 0; addr = 20'h000b6; we = 1'b0; byte_m = 1'b0; wr_data = 16'hA55A; m_io = 1'b1;
    #1;
    n_checks++;
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL ww_ready_c0: got %b want 0", rdy0); end
    @(posedge clk); #1;
    n_checks++;
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL ww_ready_c1: got %b want 1", rdy0); end
    model_write(0, 16'h00b6, 1'b0, 16'hA55A);
    @(posedge clk); #1;
    n_checks++;
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL ww_ready_c2: got %b want 0", rdy0); end
    m_io = 1'b0;
    we   = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (lv0 !== 1'b1 || ld0 !== 32'h00B6_A55A || int'(lc0) !== 1) begin
      n_fail++;
      $display("FAIL ww_log: got lv %b data %h cnt %0d want 1 00b6a55a 1", lv0, ld0, lc0);
    end
    do_access(0, 16'h00b6, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'hA55A || early !== 16'h0000 || lows !== 1) begin
      n_fail++;
      $display("FAIL ww_read: got %h early %h lows %0d want a55a 0000 1", rdv, early, lows);
    end
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rdv, early;
    int lows;
    do_access(0, 16'h00b7, 1'b1, 1'b1, 16'h003C, rdv, early, lows);
    model_write(0, 16'h00b7, 1'b1, 16'h003C);
    n_checks++;
    if (lows !== 1) begin n_fail++; $display("FAIL bl_write_lows: got %0d want 1", lows); end
    do_access(0, 16'h00b6, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h3C5A) begin n_fail++; $display("FAIL bl_word_read: got %h want 3c5a", rdv); end
    do_access(0, 16'h00b7, 1'b0, 1'b1, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h003C) begin n_fail++; $display("FAIL bl_byte_hi: got %h want 003c", rdv); end
    do_access(0, 16'h00b6, 1'b0, 1'b1, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h005A) begin n_fail++; $display("FAIL bl_byte_lo: got %h want 005a", rdv); end
    do_access(0, 16'h00b6, 1'b1, 1'b1, 16'hFF99, rdv, early, lows);
    model_write(0, 16'h00b6, 1'b1, 16'hFF99);
    do_access(0, 16'h00b6, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== model_read(0, 16'h00b6, 1'b0)) begin
      n_fail++; $display("FAIL bl_lo_write: got %h want %h", rdv, model_read(0, 16'h00b6, 1'b0));
    end
    do_access(0, 16'h00b7, 1'b1, 1'b0, 16'h1234, rdv, early, lows);
    model_write(0, 16'h00b7, 1'b0, 16'h1234);
    do_access(0, 16'h00b6, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== model_read(0, 16'h00b6, 1'b0)) begin
      n_fail++; $display("FAIL bl_odd_word: got %h want %h", rdv, model_read(0, 16'h00b6, 1'b0));
    end
    drain_log(0, "bl");
  endtask

  task automatic test_wait_states();
    logic [15:0] rdv, early;
    int lows, c0;
    do_access(3, 16'h00b0, 1'b1, 1'b0, 16'hBEEF, rdv, early, lows);
    model_write(3, 16'h00b0, 1'b0, 16'hBEEF);
    n_checks++;
    if (lows !== 4) begin n_fail++; $display("FAIL ws_write_lows: got %0d want 4", lows); end
    do_access(3, 16'h00b0, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'hBEEF || early !== 16'h0000 || lows !== 4) begin
      n_fail++; $display("FAIL ws_read: got %h early %h lows %0d want beef 0000 4", rdv, early, lows);
    end
    do_access(3, 16'h0080, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h0000 || lows !== 0) begin
      n_fail++; $display("FAIL ws_outside_read: got %h lows %0d want 0000 0", rdv, lows);
    end
    c0 = cnt_s;
    do_access(3, 16'h0080, 1'b1, 1'b0, 16'h5A5A, rdv, early, lows);
    #1;
    n_checks++;
    if (lows !== 0 || cnt_s !== c0) begin
      n_fail++; $display("FAIL ws_outside_write: got lows %0d count %0d want 0 %0d", lows, cnt_s, c0);
    end
    @(posedge clk); #1;
    drain_log(3, "ws");
  endtask

  task automatic test_log_full();
    logic [15:0] rdv, early;
    int lows;
    for (int i = 0; i < 4; i++) begin
      do_access(0, 16'h00b0 + 16'(2 * i), 1'b1, 1'b0, 16'hC0DE ^ 16'(i), rdv, early, lows);
      model_write(0, 16'h00b0 + 16'(2 * i), 1'b0, 16'hC0DE ^ 16'(i));
    end
    sel = 0;
    #1;
    n_checks++;
    if (int'(lc0) !== 4 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL lf_full: got count %0d ovf %b want 4 0", lc0, ovf0);
    end
    @(posedge clk); #1;
    // Pop on the commit edge of a write while the log is full.
    addr = 20'h000b8; we = 1'b0; byte_m = 1'b0; wr_data = 16'h7E57; m_io = 1'b1;
    #1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL lf_pp_ready: got %b want 1", rdy0); end
    log_pop = 1'b1;
    void'(exp0.pop_front());
    model_write(0, 16'h00b8, 1'b0, 16'h7E57);
    @(posedge clk); #1;
    log_pop = 1'b0;
    m_io    = 1'b0;
    we      = 1'b1;
    #1;
    n_checks++;
    if (int'(lc0) !== 4 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL lf_push_pop: got count %0d ovf %b want 4 0", lc0, ovf0);
    end
    @(posedge clk); #1;
    do_access(0, 16'h00ba, 1'b1, 1'b0, 16'h0BAD, rdv, early, lows);
    model_write(0, 16'h00ba, 1'b0, 16'h0BAD);
    #1;
    n_checks++;
    if (int'(lc0) !== 4 || ovf0 !== eovf0) begin
      n_fail++; $display("FAIL lf_overflow: got count %0d ovf %b want 4 %b", lc0, ovf0, eovf0);
    end
    @(posedge clk); #1;
    do_access(0, 16'h00ba, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== model_read(0, 16'h00ba, 1'b0)) begin
      n_fail++; $display("FAIL lf_dropped_reg: got %h want %h", rdv, model_read(0, 16'h00ba, 1'b0));
    end
    drain_log(0, "lf");
    n_checks++;
    if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL lf_sticky: got %b want 1", ovf0); end
  endtask

  task automatic test_rst_abort();
    logic [15:0] rdv, early;
    int lows;
    sel = 3; addr = 20'h000bc; we = 1'b0; byte_m = 1'b0; wr_data = 16'h7777; m_io = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ra_waiting: got %b want 0", rdy3); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ra_idle_after_rst: got %b want 0", rdy3); end
    m_io = 1'b0;
    we   = 1'b1;
    rst  = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (lv3 !== 1'b0 || int'(lc3) !== 0 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ra_log_clear: got lv %b cnt %0d ovf0 %b want 0 0 0", lv3, lc3, ovf0);
    end
    @(posedge clk); #1;
    do_access(3, 16'h00bc, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h0000 || lows !== 4) begin
      n_fail++; $display("FAIL ra_reg_unchanged: got %h lows %0d want 0000 4", rdv, lows);
    end
    do_access(3, 16'h00bc, 1'b1, 1'b0, 16'h7777, rdv, early, lows);
    model_write(3, 16'h00bc, 1'b0, 16'h7777);
    do_access(3, 16'h00bc, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h7777 || lows !== 4) begin
      n_fail++; $display("FAIL ra_next_access: got %h lows %0d want 7777 4", rdv, lows);
    end
    drain_log(3, "ra");
  endtask

  task automatic test_boundary();
    logic [15:0] rdv, early;
    int lows;
    do_access(0, 16'h00bf, 1'b1, 1'b1, 16'h00E1, rdv, early, lows);
    model_write(0, 16'h00bf, 1'b1, 16'h00E1);
    do_access(0, 16'h00be, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'hE100) begin n_fail++; $display("FAIL bd_last_port: got %h want e100", rdv); end
    do_access(0, 16'h00c0, 1'b1, 1'b0, 16'h5555, rdv, early, lows);
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL bd_past_end_lows: got %0d want 0", lows); end
    do_access(0, 16'h00c0, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h0000 || lows !== 0) begin
      n_fail++; $display("FAIL bd_past_end_read: got %h lows %0d want 0000 0", rdv, lows);
    end
    do_access(0, 16'h00af, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== 16'h0000 || lows !== 0) begin
      n_fail++; $display("FAIL bd_below_base: got %h lows %0d want 0000 0", rdv, lows);
    end
    do_access(0, 16'h00b0, 1'b0, 1'b0, 16'h0, rdv, early, lows);
    n_checks++;
    if (rdv !== model_read(0, 16'h00b0, 1'b0)) begin
      n_fail++; $display("FAIL bd_first_reg: got %h want %h", rdv, model_read(0, 16'h00b0, 1'b0));
    end
    drain_log(0, "bd");
  endtask

  task automatic test_back_to_back();
    logic [15:0] rdv, early;
    int lows1, lows2;
    do_access(0, 16'h00b2, 1'b1, 1'b0, 16'h1111, rdv, early, lows1);
    model_write(0, 16'h00b2, 1'b0, 16'h1111);
    do_access(0, 16'h00b4, 1'b1, 1'b0, 16'h2222, rdv, early, lows2);
    model_write(0, 16'h00b4, 1'b0, 16'h2222);
    n_checks++;
    if (lows1 !== 1 || lows2 !== 1) begin
      n_fail++; $display("FAIL b2b_write_lows: got %0d %0d want 1 1", lows1, lows2);
    end
    do_access(0, 16'h00b2, 1'b0, 1'b0, 16'h0, rdv, early, lows1);
    n_checks++;
    if (rdv !== model_read(0, 16'h00b2, 1'b0)) begin
      n_fail++; $display("FAIL b2b_read_a: got %h want %h", rdv, model_read(0, 16'h00b2, 1'b0));
    end
    do_access(0, 16'h00b5, 1'b0, 1'b1, 16'h0, rdv, early, lows1);
    n_checks++;
    if (rdv !== model_read(0, 16'h00b5, 1'b1)) begin
      n_fail++; $display("FAIL b2b_read_b: got %h want %h", rdv, model_read(0, 16'h00b5, 1'b1));
    end
    drain_log(0, "b2b");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_word_write();
    test_byte_lanes();
    test_wait_states();
    test_log_full();
    test_rst_abort();
    test_boundary();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
